// File: rtl/cht_shift_ctrl.sv
// Sequential shift controller feeding the cht shift/select network; applies one single-position shift per clock.
// Latency: result valid c cycles after the acceptance edge for count c (one cycle passthrough for c = 0).
// Backpressure: one command in flight; cmd_ready low until the result is taken; res_ready low holds DONE indefinitely.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_data operand, cmd_dir (0 left, 1 right),
//                               cmd_cnt shift count, cmd_fill bit shifted into vacated position
//   res_valid/res_ready         result handshake; res_data shifted word
//   busy                        high whenever not IDLE (always ~cmd_ready)
//   sel_shift, sel_dir          network selects: shift-this-cycle and latched direction
module cht_shift_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             sel_shift,
  output logic             sel_dir
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  // Mirror of the network's one-position shift. Counts >= WIDTH simply keep
  // shifting, so the word ends up entirely fill bits.
  always_comb begin
    shifted = '0;
    if (dir_q) begin
      shifted = {fill_q, data_q[WIDTH-1:1]};
    end else begin
      shifted = {data_q[WIDTH-2:0], fill_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    sel_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          rem_d   = cmd_cnt;
          fill_d  = cmd_fill;
          // A zero count skips SHIFT entirely: the operand is the result.
          state_d = (cmd_cnt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        sel_shift = 1'b1;
        data_d    = shifted;
        rem_d     = rem_q - CNT_W'(1);
        // The edge that consumes the last remaining shift also leaves SHIFT.
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = ~cmd_ready;
  assign res_data = data_q;
  assign sel_dir  = dir_q;

endmodule

// File: tb/tb_cht_shift_ctrl.sv
module tb_cht_shift_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;
  logic             sel_shift;
  logic             sel_dir;

  int vectors;
  int miscompares;

  cht_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .sel_shift (sel_shift),
    .sel_dir   (sel_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, then counts cycles (sampled 1 time unit after each
  // edge) from the acceptance edge until res_valid. lat = 0 means res_valid
  // right after the acceptance edge. Leaves res_ready untouched.
  task automatic run_cmd(input logic [WIDTH-1:0] d, input logic dir,
                         input logic [CNT_W-1:0] c, input logic fill,
                         output int lat, output int shifts,
                         output logic dir_bad, output logic busy_bad);
    int wait_cyc;
    lat      = 0;
    shifts   = 0;
    dir_bad  = 1'b0;
    busy_bad = 1'b0;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_cnt   = c;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    wait_cyc  = 0;
    while (!cmd_ready && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    tick();
    cmd_valid = 1'b0;
    while (!res_valid && lat < 64) begin
      if (sel_shift) shifts++;
      if (sel_shift && sel_dir !== dir) dir_bad = 1'b1;
      if (busy !== ~cmd_ready) busy_bad = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({cmd_ready, res_valid, busy, sel_shift, sel_dir} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/vld/busy/shift/dir=%b expected 10000",
               {cmd_ready, res_valid, busy, sel_shift, sel_dir});
    end
    vectors++;
    if (res_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0000", res_data);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_left_shift();
    int lat, shifts;
    logic dir_bad, busy_bad;
    run_cmd(16'h00F0, 1'b0, 4'd4, 1'b0, lat, shifts, dir_bad, busy_bad);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL left_latency: got %0d expected 4", lat);
    end
    vectors++;
    if (shifts !== 4 || dir_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL left_selects: got shifts=%0d dir_bad=%b expected 4/0", shifts, dir_bad);
    end
    vectors++;
    if (res_data !== 16'h0F00) begin
      miscompares++;
      $display("FAIL left_data: got %h expected 0f00", res_data);
    end
    vectors++;
    if (busy_bad !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL left_busy: got busy_bad=%b busy=%b expected 0/1", busy_bad, busy);
    end
    take_result();
    vectors++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL left_handshake: got vld=%b rdy=%b busy=%b expected 0/1/0",
               res_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_right_shift();
    int lat, shifts;
    logic dir_bad, busy_bad;
    run_cmd(16'h8001, 1'b1, 4'd1, 1'b1, lat, shifts, dir_bad, busy_bad);
    vectors++;
    if (lat !== 1 || shifts !== 1 || dir_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL right_timing: got lat=%0d shifts=%0d dir_bad=%b expected 1/1/0",
               lat, shifts, dir_bad);
    end
    vectors++;
    if (res_data !== 16'hC000) begin
      miscompares++;
      $display("FAIL right_data: got %h expected c000", res_data);
    end
    take_result();
  endtask

  task automatic test_zero_count();
    int lat, shifts;
    logic dir_bad, busy_bad;
    run_cmd(16'hA5A5, 1'b0, 4'd0, 1'b0, lat, shifts, dir_bad, busy_bad);
    vectors++;
    if (lat !== 0 || shifts !== 0 || sel_shift !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_timing: got lat=%0d shifts=%0d sel_shift=%b expected 0/0/0",
               lat, shifts, sel_shift);
    end
    vectors++;
    if (res_data !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL zero_data: got %h expected a5a5", res_data);
    end
    take_result();
  endtask

  task automatic test_stall();
    int lat, shifts;
    logic dir_bad, busy_bad;
    logic stall_bad;
    run_cmd(16'h0001, 1'b0, 4'd15, 1'b1, lat, shifts, dir_bad, busy_bad);
    vectors++;
    if (lat !== 15 || shifts !== 15) begin
      miscompares++;
      $display("FAIL max_timing: got lat=%0d shifts=%0d expected 15/15", lat, shifts);
    end
    // Offer a competing command while the result is stalled.
    cmd_data  = 16'h1111;
    cmd_dir   = 1'b1;
    cmd_cnt   = 4'd2;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    stall_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 16'hFFFF || cmd_ready !== 1'b0)
        stall_bad = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (stall_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold: got unstable result or cmd_ready during stall");
    end
    vectors++;
    if (res_data !== 16'hFFFF || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_data: got %h vld=%b expected ffff/1", res_data, res_valid);
    end
    take_result();
  endtask

  task automatic test_reset_mid_shift();
    int lat, shifts;
    logic dir_bad, busy_bad;
    logic seen_vld;
    cmd_data  = 16'h0F0F;
    cmd_dir   = 1'b1;
    cmd_cnt   = 4'd8;
    cmd_fill  = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, res_valid, busy, sel_shift, sel_dir} !== 5'b10000 || res_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got ctrl=%b data=%h expected 10000/0000",
               {cmd_ready, res_valid, busy, sel_shift, sel_dir}, res_data);
    end
    #2 rst_n = 1'b1;
    seen_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) seen_vld = 1'b1;
    end
    vectors++;
    if (seen_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_novalid: got res_valid pulse expected none");
    end
    run_cmd(16'hFFFF, 1'b1, 4'd3, 1'b0, lat, shifts, dir_bad, busy_bad);
    vectors++;
    if (lat !== 3 || res_data !== 16'h1FFF) begin
      miscompares++;
      $display("FAIL midreset_recover: got lat=%0d data=%h expected 3/1fff", lat, res_data);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic             vld_h [8];
    logic             rdy_h [8];
    logic [WIDTH-1:0] dat_h [8];
    int first, second, idle_between;
    res_ready = 1'b1;
    cmd_data  = 16'h1234;
    cmd_dir   = 1'b0;
    cmd_cnt   = 4'd2;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    tick();
    // Second command is offered continuously right after the first is taken.
    cmd_data = 16'h00FF;
    cmd_dir  = 1'b1;
    cmd_cnt  = 4'd1;
    cmd_fill = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vld_h[k] = res_valid;
      rdy_h[k] = cmd_ready;
      dat_h[k] = res_data;
      if (k == 4) cmd_valid = 1'b0;
      tick();
    end
    res_ready = 1'b0;
    first  = -1;
    second = -1;
    for (int k = 0; k < 8; k++) begin
      if (vld_h[k] === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    vectors++;
    if (first !== 2 || dat_h[2] !== 16'h48D0) begin
      miscompares++;
      $display("FAIL b2b_first: got at=%0d data=%h expected 2/48d0", first, dat_h[2]);
    end
    vectors++;
    if (second !== 5 || dat_h[5] !== 16'h807F) begin
      miscompares++;
      $display("FAIL b2b_second: got at=%0d data=%h expected 5/807f", second, dat_h[5]);
    end
    idle_between = 0;
    for (int k = 3; k < 5; k++) begin
      if (rdy_h[k] === 1'b1) idle_between++;
    end
    vectors++;
    if (idle_between !== 1 || rdy_h[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: got idle_cycles=%0d expected 1", idle_between);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    cmd_dir     = 1'b0;
    cmd_cnt     = '0;
    cmd_fill    = 1'b0;
    res_ready   = 1'b0;

    test_reset();
    test_left_shift();
    test_right_shift();
    test_zero_count();
    test_stall();
    test_reset_mid_shift();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cht_shift_ctrl.md
# cht_shift_ctrl

Sequential control stage directly upstream of the `cht` shift/select network. It accepts a shift command over a valid/ready handshake, holds the operand in a register, and applies one single-position shift per clock. It drives the network's select lines every cycle and returns the final word over a second valid/ready handshake. The block is self-contained: its internal datapath reproduces the network's one-position shift, so the block can be verified standalone.

## Interface
- `WIDTH`, default 16: data word width.
- `CNT_W`, default 4: shift-count width. Maximum count is 2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_data`  in  WIDTH  operand.
- `cmd_dir`  in  1  shift direction: 0 = left (toward MSB), 1 = right.
- `cmd_cnt`  in  CNT_W  number of single-position shifts.
- `cmd_fill`  in  1  bit shifted into the vacated position.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  shifted word.
- `busy`  out  1  high whenever the state is not IDLE.
- `sel_shift`  out  1  network select: 1 means shift this cycle, 0 means hold.
- `sel_dir`  out  1  network direction select; equals the latched `cmd_dir`.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid` & `cmd_ready`, latch data, dir, cnt and fill.
  - Go to SHIFT if cnt ≠ 0, otherwise go to DONE.
- **SHIFT**
  - Every cycle: register ← shift-by-one with fill, and remaining ← remaining − 1.
  - When remaining reaches 1, that edge performs the last shift and moves to DONE.
  - `sel_shift` = 1 only in this state.
- **DONE**
  - `res_valid` = 1 and `res_data` = register, both held stable.
  - On `res_valid` & `res_ready`, go to IDLE.
- Shift arithmetic:
  - Left: `{reg[WIDTH-2:0], fill}`.
  - Right: `{fill, reg[WIDTH-1:1]}`.
  - Counts ≥ WIDTH fully replace the word with fill bits (no modulo).
- `cmd_valid` outside IDLE is ignored. There is no queueing, and upstream must hold the command until `cmd_ready`.
- `res_data` is defined only while `res_valid` = 1. It holds the register value otherwise.

## Timing
- Reset (asynchronous assert, synchronous release by the clock domain):
  - State = IDLE.
  - `cmd_ready` = 1.
  - `res_valid` = 0, `res_data` = 0.
  - `busy` = 0, `sel_shift` = 0, `sel_dir` = 0.
  - Internal registers = 0.
- Acceptance at edge N with count c:
  - c > 0: SHIFT during cycles N..N+c−1. `res_valid` rises after edge N+c.
  - c = 0: `res_valid` rises after edge N, giving one-cycle passthrough.
- Result handshake at edge M: `res_valid` falls and `cmd_ready` rises after M. The earliest next acceptance is edge M+1; there is no same-edge turnaround.
- `busy` = ~`cmd_ready` in every cycle.
- Reset asserted mid-SHIFT or mid-DONE:
  - Immediate return to IDLE, with all outputs at their reset values.
  - The in-flight result is discarded and no `res_valid` pulse occurs.
- `res_ready` held low keeps DONE indefinitely, with `res_data` unchanged.

## Test plan
- Left shift, data 0x00F0, cnt 4, fill 0 → `res_data` 0x0F00.
  - `res_valid` asserted exactly 4 cycles after the acceptance edge.
  - `sel_shift` high for 4 cycles and `sel_dir` = 0.
- Right shift, data 0x8001, cnt 1, fill 1 → 0xC000, with `res_valid` one cycle after acceptance.
- cnt 0, data 0xA5A5 → 0xA5A5, `res_valid` on the next cycle, `sel_shift` never high.
- Left shift, data 0x0001, cnt 15, fill 1, with `res_ready` low for 5 cycles after `res_valid`:
  - Result 0xFFFF, held stable across the stall.
  - A second `cmd_valid` during the stall is not accepted (`cmd_ready` = 0).
- `rst_n` pulsed low during SHIFT of cnt 8:
  - All outputs return to reset values immediately.
  - No `res_valid` is seen afterwards.
  - A new command, right shift of 0xFFFF with cnt 3 and fill 0, then yields 0x1FFF.
- Back-to-back commands with `res_ready` tied high:
  - Exactly one idle cycle (`cmd_ready` = 1) between results.
  - The second result is correct and independent of the first.
